try_pipe: RTL and testbench
===========================

TRY_PIPE -- requirements
Module: try_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  word present at the output.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the word this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  output payload.
REQ-011 SHALL have port flush  input  1  synchronous discard of all held words.
REQ-012 SHALL have port occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-013 SHALL implement DEPTH stages, stage 0 input-side and stage DEPTH-1 output-side, each holding a valid bit and a WIDTH data register.
REQ-014 SHALL define transfer as valid&&ready on either port; words SHALL leave in acceptance order, with none lost or duplicated.
REQ-015 SHALL compute stage-k ready as !valid[k] || ready[k+1], with ready[DEPTH] = out_ready (a combinational chain; bubbles collapse).
REQ-016 SHALL drive in_ready = ready[0] && !flush.
REQ-017 SHALL drive out_valid = valid[DEPTH-1] and out_data = data[DEPTH-1], both straight from registers.
REQ-018 SHALL move stage k into stage k+1 when ready[k+1] is high; stage 0 SHALL load in_data on an input transfer.
REQ-019 SHALL give latency of exactly DEPTH cycles from input transfer to out_valid when downstream never stalls; full throughput is 1 word/cycle.
REQ-020 SHALL, when full with out_ready high, accept a new input in the same cycle as an output transfer.
REQ-021 SHALL keep out_data stable while out_valid && !out_ready.
REQ-022 SHALL maintain occupancy as a registered counter: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither; it SHALL always equal the popcount of the valid bits.
REQ-023 SHALL, on flush high, clear all valid bits and set occupancy to 0 at the next edge; in_ready is low and any in_valid is dropped; an output transfer in that cycle still counts as delivered.
REQ-024 SHALL leave data registers unchanged when the stage is not loaded.

Reset
REQ-025 SHALL, while rst_n is low at a clock edge, clear all valid bits, all data registers to 0, and occupancy to 0.
REQ-026 SHALL, after reset, present out_valid=0, out_data=0, occupancy=0, and in_ready=1 (when flush is low).
REQ-027 SHALL give reset priority over flush and over any transfer, including mid-stream.

Structure
REQ-028 SHALL take default WIDTH/DEPTH constants and the occupancy-width function from shared package try_pkg.
REQ-029 SHALL build each stage from sub-module try_pipe_stage (valid+data register with load/clear), instantiated DEPTH times by generate loop.

Verification (WIDTH=8, DEPTH=3)
REQ-030 SHALL cover reset: rst_n low 1 cycle mid-stream -> out_valid=0, out_data=0x00, occupancy=0, in_ready=1.
REQ-031 SHALL cover streaming: push 0x01..0x05 back-to-back with out_ready=1 -> 0x01 on output 3 cycles after its transfer, then 0x02..0x05 on consecutive cycles.
REQ-032 SHALL cover backpressure: out_ready=0, offer 0xA0..0xA3 -> 0xA0..0xA2 accepted, in_ready=0 on 0xA3, occupancy=3; raise out_ready -> 0xA3 accepted the same cycle 0xA0 leaves, order preserved.
REQ-033 SHALL cover bubble collapse: out_ready=0, single 0x55 -> at output after 3 cycles; then 0x66 and 0x77 are accepted, occupancy=3.
REQ-034 SHALL cover flush: full pipe plus in_valid=1 with 0x99 and flush=1 -> next cycle occupancy=0, out_valid=0, 0x99 never emitted.
REQ-035 SHALL cover simultaneous transfer: full pipe, in_valid=1 and out_ready=1 for 10 cycles -> occupancy stays 3 and output sequence matches input.

Source files
------------

// File: rtl/try_pkg.sv
// Shared constants for the try_pipe elastic pipeline: default geometry and
// the width of the occupancy counter.
package try_pkg;

  localparam int TRY_WIDTH = 8;
  localparam int TRY_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/try_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register. The stage takes new
// content when enabled and drops its valid bit on clear.
module try_pipe_stage
  import try_pkg::*;
#(
  parameter int WIDTH = TRY_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Data only moves with a real word, so bubbles passing through leave it alone.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/try_pipe.sv
// Elastic DEPTH-stage register pipeline with bubble collapse, flush and a
// registered occupancy count.
module try_pipe
  import try_pkg::*;
#(
  parameter int WIDTH = TRY_WIDTH,
  parameter int DEPTH = TRY_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          flush,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OW = occ_width(DEPTH);

  // Handshake: a word moves across a port on a cycle where valid && ready are
  // both high; the sender holds valid and data stable until that cycle, and
  // ready may depend combinationally on the downstream ready chain.
  logic [DEPTH-1:0] valid_w;
  logic [WIDTH-1:0] data_w [DEPTH];
  logic [DEPTH:0]   ready_w;
  logic             in_xfer;
  logic             out_xfer;
  logic [OW-1:0]    occ_q, occ_d;

  // A stage can take a word if it is empty or its occupant moves on.
  always_comb begin
    ready_w        = '0;
    ready_w[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready_w[k] = !valid_w[k] || ready_w[k+1];
    end
  end

  assign in_ready = ready_w[0] && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_w[DEPTH-1] && out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             stg_valid_in;
    logic [WIDTH-1:0] stg_data_in;
    if (k == 0) begin : g_head
      assign stg_valid_in = in_xfer;
      assign stg_data_in  = in_data;
    end else begin : g_body
      assign stg_valid_in = valid_w[k-1];
      assign stg_data_in  = data_w[k-1];
    end
    try_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ready_w[k]),
      .clear_i (flush),
      .valid_i (stg_valid_in),
      .data_i  (stg_data_in),
      .valid_o (valid_w[k]),
      .data_o  (data_w[k])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OW'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
  assign out_valid = valid_w[DEPTH-1];
  assign out_data  = data_w[DEPTH-1];

endmodule

// File: tb/tb_try_pipe.sv
// Directed and random checks of try_pipe (WIDTH=8, DEPTH=3) against an
// ordered-queue model of the words held in the pipeline.
module tb_try_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  int tests  = 0;
  int failed = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             stall_q    = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;

  try_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then update the model.
  task automatic cyc();
    logic ixf, oxf;
    @(negedge clk);
    ixf = in_valid && in_ready;
    oxf = out_valid && out_ready;
    if (rst_n) begin
      chk("in_ready", in_ready, !flush && (exp_q.size() < DEPTH || out_ready));
      chk("occupancy", occupancy, exp_q.size());
      chk("spurious_valid", out_valid && (exp_q.size() == 0), 0);
      if (stall_q) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, stall_data);
      end
      if (oxf && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
    end
    stall_q    = rst_n && !flush && out_valid && !out_ready;
    stall_data = out_data;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (oxf && exp_q.size() > 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (ixf) exp_q.push_back(in_data);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);

    // streaming 0x01..0x05
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 5);
      in_data  = 8'(i + 1);
      cyc();
      chk("stream_valid", out_valid, (i >= 2 && i <= 6));
      if (i >= 2 && i <= 6) chk("stream_data", out_data, i - 1);
    end

    // reset mid-stream
    in_valid = 1'b1;
    in_data = 8'h10; cyc();
    in_data = 8'h11; cyc();
    rst_n = 1'b0; in_data = 8'h12; cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_ready", in_ready, 1);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i);
      cyc();
    end
    chk("bp_occ", occupancy, 3);
    chk("bp_ready_a3", in_ready, 0);
    out_ready = 1'b1;
    cyc();
    chk("bp_swap_occ", occupancy, 3);
    in_valid = 1'b0;
    repeat (5) cyc();
    chk("bp_drained", occupancy, 0);

    // bubble collapse
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    chk("bubble_valid", out_valid, 1);
    chk("bubble_data", out_data, 8'h55);
    in_valid = 1'b1;
    in_data = 8'h66; cyc();
    in_data = 8'h77; cyc();
    in_valid = 1'b0;
    chk("bubble_occ", occupancy, 3);
    cyc();

    // flush while full with a word offered
    in_valid = 1'b1; in_data = 8'h99; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (5) cyc();

    // simultaneous transfer on a full pipe
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      cyc();
      chk("sim_occ", occupancy, 3);
    end
    in_valid = 1'b0;
    repeat (5) cyc();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = 8'($urandom);
      cyc();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();
    chk("final_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
